// File: rtl/render_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : render_frame_sequencer_if                                     |
// | Brief    : Bundle of the frame request, vertex/parameter snapshot,       |
// |            rasterizer start/done and display swap signals of the frame   |
// |            sequencer. The slave modport is the sequencer's view; the      |
// |            master modport is the view of the surrounding pipeline.       |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface render_frame_sequencer_if #(
  parameter int NSURF = 4,
  parameter int VW    = 36,
  parameter int PW    = 6
);

  logic                    frame_req;
  logic                    frame_ack;
  logic [NSURF*3*VW-1:0]   vertex_in;
  logic [NSURF*6*PW-1:0]   para_in;
  logic [NSURF*3*VW-1:0]   vertex_out;
  logic [NSURF*6*PW-1:0]   para_out;
  logic                    draw_start;
  logic                    draw_done;
  logic                    vsync;
  logic                    buf_sel;
  logic                    busy;
  logic [15:0]             frame_count;
  logic                    error;

  // Transform stage, rasterizer and display side.
  modport master (
    output frame_req, vertex_in, para_in, draw_done, vsync,
    input  frame_ack, vertex_out, para_out, draw_start, buf_sel, busy,
           frame_count, error
  );

  // Sequencer side.
  modport slave (
    input  frame_req, vertex_in, para_in, draw_done, vsync,
    output frame_ack, vertex_out, para_out, draw_start, buf_sel, busy,
           frame_count, error
  );

endinterface
`default_nettype wire

// File: rtl/render_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : render_frame_sequencer                                        |
// | Brief    : Frame-level controller for the surface rasterizer. Snapshots  |
// |            vertices and surface parameters into shadow registers,        |
// |            pulses the rasterizer start, waits for its done pulse and     |
// |            then swaps the displayed framebuffer on the next vsync edge.  |
// | Options  : `define RENDER_WATCHDOG_EN adds a draw watchdog that aborts    |
// |            a frame after TIMEOUT cycles in DRAW and sets a sticky error. |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module render_frame_sequencer #(
  parameter int NSURF   = 4,
  parameter int VW      = 36,
  parameter int PW      = 6,
  parameter int TIMEOUT = 400000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  render_frame_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LATCH     = 3'd1,
    S_START     = 3'd2,
    S_DRAW      = 3'd3,
    S_SWAP_WAIT = 3'd4,
    S_SWAP      = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_vsync_q;
  logic                    w_vsync_rise;
  logic                    w_timeout;

  logic                    r_frame_ack;
  logic                    r_draw_start;
  logic                    r_busy;
  logic                    r_buf_sel;
  logic [15:0]             r_frame_count;
  logic [NSURF*3*VW-1:0]   r_vertex;
  logic [NSURF*6*PW-1:0]   r_para;

  // Only a rising edge seen while waiting to swap counts; an edge that
  // happened earlier leaves r_vsync_q high and is therefore invisible here.
  assign w_vsync_rise = bus.vsync & ~r_vsync_q;

`ifdef RENDER_WATCHDOG_EN
  // Counter holds the number of DRAW cycles already spent, so the terminal
  // value TIMEOUT-1 marks the TIMEOUT-th cycle of the draw.
  localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  logic [c_WD_W-1:0]       r_wd_cnt;
  logic                    r_error;

  // Draw cycle counter, held at zero outside DRAW so each draw starts fresh.
  always_ff @(posedge Clk) begin
    if (Reset || (r_state != S_DRAW)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_DRAW) && (r_wd_cnt == c_WD_LAST);

  // Sticky error; a done pulse arriving on the timeout cycle takes priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_error <= 1'b0;
    end else if (w_timeout && !bus.draw_done) begin
      r_error <= 1'b1;
    end
  end

  assign bus.error = r_error;
`else
  // No watchdog: the draw may take as long as the rasterizer needs.
  assign w_timeout = 1'b0;
  assign bus.error = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_req) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_state_nxt = S_START;
      end
      S_START: begin
        w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (bus.draw_done) begin
          w_state_nxt = S_SWAP_WAIT;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SWAP_WAIT: begin
        if (w_vsync_rise) begin
          w_state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so each one lines up
  // with the cycle the FSM actually sits in the corresponding state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vsync_q     <= 1'b0;
      r_frame_ack   <= 1'b0;
      r_draw_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_frame_count <= 16'd0;
      r_vertex      <= '0;
      r_para        <= '0;
    end else begin
      r_vsync_q    <= bus.vsync;
      r_frame_ack  <= (w_state_nxt == S_LATCH);
      r_draw_start <= (w_state_nxt == S_START);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_LATCH) begin
        r_vertex <= bus.vertex_in;
        r_para   <= bus.para_in;
      end
      if (w_state_nxt == S_SWAP) begin
        r_buf_sel     <= ~r_buf_sel;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.frame_ack   = r_frame_ack;
  assign bus.draw_start  = r_draw_start;
  assign bus.busy        = r_busy;
  assign bus.buf_sel     = r_buf_sel;
  assign bus.frame_count = r_frame_count;
  assign bus.vertex_out  = r_vertex;
  assign bus.para_out    = r_para;

endmodule
`default_nettype wire

// File: tb/tb_render_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_render_frame_sequencer                                     |
// | Brief    : Self-checking bench for render_frame_sequencer. Frames are    |
// |            described by per-cycle plans of draw_done and vsync; the     |
// |            expected swap cycle comes from a table or from a frame-level |
// |            model and every output is compared on every cycle.           |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_render_frame_sequencer;

  localparam int NSURF   = 4;
  localparam int VW      = 36;
  localparam int PW      = 6;
  localparam int TIMEOUT = 1000;
  localparam int VBITS   = NSURF*3*VW;
  localparam int PBITS   = NSURF*6*PW;
  localparam int W       = 1100;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  render_frame_sequencer_if #(.NSURF(NSURF), .VW(VW), .PW(PW)) bus ();

  render_frame_sequencer #(
    .NSURF(NSURF), .VW(VW), .PW(PW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Frame plans, indexed by cycle offset from the request cycle.
  logic vs_plan [W];
  logic dd_plan [W];

  // Bench-side expectation of the architectural state.
  logic        m_buf = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_err = 1'b0;

  typedef struct {
    int          d;        // draw_done offset
    int          pre;      // extra vsync pulse offset (0 = none)
    int          e;        // vsync pulse that should cause the swap
    int          swap;     // offset at which buf_sel flips
    logic        exp_buf;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int o,
                     input logic [VBITS-1:0] act, input logic [VBITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @off %0d: got %0h expected %0h", name, o, act, exp);
    end
  endtask

  function automatic logic [VBITS-1:0] rand_v();
    logic [VBITS-1:0] v = '0;
    for (int i = 0; i < VBITS/16; i++) v = {v[VBITS-17:0], 16'($urandom())};
    return v;
  endfunction

  task automatic clear_plans();
    for (int i = 0; i < W; i++) begin
      vs_plan[i] = 1'b0;
      dd_plan[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    Reset         = 1'b1;
    bus.frame_req = 1'b0;
    bus.draw_done = 1'b0;
    bus.vsync     = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    m_buf = 1'b0;
    m_cnt = 16'd0;
    m_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   0, VBITS'(bus.frame_ack),   '0);
    chk({tag, "_start"}, 0, VBITS'(bus.draw_start),  '0);
    chk({tag, "_busy"},  0, VBITS'(bus.busy),        '0);
    chk({tag, "_err"},   0, VBITS'(bus.error),       '0);
    chk({tag, "_buf"},   0, VBITS'(bus.buf_sel),     '0);
    chk({tag, "_cnt"},   0, VBITS'(bus.frame_count), '0);
    chk({tag, "_vtx"},   0, bus.vertex_out,          '0);
    chk({tag, "_para"},  0, VBITS'(bus.para_out),    '0);
  endtask

  // Frame-level rule: drawing begins three cycles after the request cycle,
  // so the first done pulse at offset >= 3 ends the draw; the buffer flips
  // one cycle after the first vsync rising edge strictly after that pulse.
  function automatic int model_swap();
    int d = -1;
    for (int o = 3; o < W; o++) begin
      if (dd_plan[o]) begin
        d = o;
        break;
      end
    end
    if (d < 0) return -1;
    for (int o = d + 1; o < W; o++) begin
      if (vs_plan[o] && !vs_plan[o-1]) return o + 1;
    end
    return -1;
  endfunction

  // Runs one frame from an IDLE cycle (offset 0) through the first IDLE
  // cycle after the swap, checking every output on every cycle.
  task automatic do_frame(input int swap_off, input bit hold_req);
    logic [VBITS-1:0] a_v;
    logic [VBITS-1:0] tmp;
    logic [PBITS-1:0] a_p;
    a_v = rand_v();
    tmp = rand_v();
    a_p = tmp[PBITS-1:0];
    if (swap_off < 5 || swap_off + 1 >= W) begin
      total++;
      bad++;
      $display("FAIL plan: swap offset %0d out of range", swap_off);
      return;
    end
    bus.frame_req = 1'b1;
    bus.draw_done = dd_plan[0];
    bus.vsync     = vs_plan[0];
    bus.vertex_in = a_v;
    bus.para_in   = a_p;
    for (int o = 1; o <= swap_off + 1; o++) begin
      tick();
      chk("ack",   o, VBITS'(bus.frame_ack),  VBITS'(o == 1));
      chk("start", o, VBITS'(bus.draw_start), VBITS'(o == 2));
      chk("busy",  o, VBITS'(bus.busy),       VBITS'(o <= swap_off));
      chk("buf",   o, VBITS'(bus.buf_sel),    VBITS'(m_buf ^ (o >= swap_off)));
      chk("cnt",   o, VBITS'(bus.frame_count),
          VBITS'(16'(m_cnt + ((o >= swap_off) ? 16'd1 : 16'd0))));
      chk("vtx",   o, bus.vertex_out,         a_v);
      chk("para",  o, VBITS'(bus.para_out),   VBITS'(a_p));
      chk("err",   o, VBITS'(bus.error),      VBITS'(m_err));
      bus.frame_req = hold_req;
      bus.draw_done = dd_plan[o];
      bus.vsync     = vs_plan[o];
      bus.vertex_in = rand_v();
      tmp           = rand_v();
      bus.para_in   = tmp[PBITS-1:0];
    end
    m_buf = ~m_buf;
    m_cnt = m_cnt + 16'd1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int sw;
    int d;

    tbl[0] = '{d: 3,  pre: 0, e: 4,  swap: 5,  exp_buf: 1'b1, exp_cnt: 16'd1};
    tbl[1] = '{d: 10, pre: 5, e: 20, swap: 21, exp_buf: 1'b0, exp_cnt: 16'd2};
    tbl[2] = '{d: 6,  pre: 6, e: 9,  swap: 10, exp_buf: 1'b1, exp_cnt: 16'd3};
    tbl[3] = '{d: 4,  pre: 0, e: 30, swap: 31, exp_buf: 1'b0, exp_cnt: 16'd4};

    bus.vertex_in = '0;
    bus.para_in   = '0;
    do_reset();
    chk_reset_vals("rst");

    // Reset in the middle of a draw, then a stray done from the aborted draw.
    bus.frame_req = 1'b1;
    bus.vertex_in = rand_v();
    for (int o = 1; o <= 4; o++) begin
      tick();
      bus.frame_req = 1'b0;
    end
    chk("middraw_busy", 4, VBITS'(bus.busy), VBITS'(1'b1));
    Reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    Reset         = 1'b0;
    bus.draw_done = 1'b1;
    tick();
    bus.draw_done = 1'b0;
    for (int o = 0; o < 6; o++) begin
      bus.vsync = o[0];
      tick();
      chk("stray_busy",  o, VBITS'(bus.busy),        '0);
      chk("stray_start", o, VBITS'(bus.draw_start),  '0);
      chk("stray_buf",   o, VBITS'(bus.buf_sel),     '0);
      chk("stray_cnt",   o, VBITS'(bus.frame_count), '0);
    end
    bus.vsync = 1'b0;

    // Table of deterministic frames.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_plans();
      dd_plan[tbl[i].d] = 1'b1;
      if (tbl[i].pre != 0) vs_plan[tbl[i].pre] = 1'b1;
      vs_plan[tbl[i].e] = 1'b1;
      do_frame(tbl[i].swap, 1'b0);
      chk("tbl_buf", i, VBITS'(bus.buf_sel),     VBITS'(tbl[i].exp_buf));
      chk("tbl_cnt", i, VBITS'(bus.frame_count), VBITS'(tbl[i].exp_cnt));
    end

    // Three frames with the request held the whole time.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_plans();
      dd_plan[5] = 1'b1;
      vs_plan[8] = 1'b1;
      do_frame(9, i < 2);
    end
    chk("b2b_cnt", 3, VBITS'(bus.frame_count), VBITS'(16'd3));
    chk("b2b_buf", 3, VBITS'(bus.buf_sel),     VBITS'(1'b1));

    // An edge during the draw is ignored; the swap waits 500 cycles.
    clear_plans();
    vs_plan[5]   = 1'b1;
    dd_plan[8]   = 1'b1;
    vs_plan[509] = 1'b1;
    do_frame(510, 1'b0);

    // Randomized frames checked against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      clear_plans();
      d = $urandom_range(3, 60);
      dd_plan[d] = 1'b1;
      if ($urandom_range(0, 1) == 1) dd_plan[$urandom_range(1, 2)] = 1'b1;
      if ($urandom_range(0, 1) == 1) dd_plan[d + $urandom_range(2, 20)] = 1'b1;
      for (int o = 1; o < d + 120; o++) vs_plan[o] = ($urandom_range(0, 5) == 0);
      vs_plan[d + 120] = 1'b0;
      vs_plan[d + 121] = 1'b1;
      sw = model_swap();
      do_frame(sw, 1'b0);
    end

`ifdef RENDER_WATCHDOG_EN
    // Withheld done: abort after TIMEOUT draw cycles, no swap.
    clear_plans();
    bus.frame_req = 1'b1;
    bus.draw_done = 1'b0;
    bus.vsync     = 1'b0;
    for (int o = 1; o <= TIMEOUT + 3; o++) begin
      tick();
      bus.frame_req = 1'b0;
      chk("wd_busy", o, VBITS'(bus.busy),  VBITS'(o <= TIMEOUT + 2));
      chk("wd_err",  o, VBITS'(bus.error), VBITS'(o >= TIMEOUT + 3));
    end
    chk("wd_buf", 0, VBITS'(bus.buf_sel),     VBITS'(m_buf));
    chk("wd_cnt", 0, VBITS'(bus.frame_count), VBITS'(m_cnt));
    m_err = 1'b1;

    // Done on the timeout cycle wins: the frame completes normally.
    clear_plans();
    dd_plan[TIMEOUT + 2] = 1'b1;
    vs_plan[TIMEOUT + 10] = 1'b1;
    do_frame(TIMEOUT + 11, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/render_frame_sequencer.md
# render_frame_sequencer

Frame-level controller for the surface rasterizer. It snapshots projected vertices and per-surface parameters from the transform stage into stable shadow registers, then pulses the rasterizer start and waits for its done pulse. Once the frame is drawn it swaps the front/back framebuffer select on the next display vsync edge. It sits between the transform pipeline and the pixel-traversal/depth-select block, and hands `buf_sel` to the framebuffer write/read muxes.

## Interface
Parameters:
- NSURF, 4, number of surfaces handled by the rasterizer
- VW, 36, width of one projected vertex word
- PW, 6, width of one surface parameter word
- TIMEOUT, 400000, draw watchdog limit in cycles (one 640x480 traversal is 307200)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- frame_req  in  1  level request to render a frame; held until frame_ack
- frame_ack  out  1  one-cycle pulse when inputs are captured
- vertex_in  in  NSURF*3*VW  projected vertices, 3 per surface
- para_in  in  NSURF*6*PW  surface parameters
- vertex_out  out  NSURF*3*VW  latched vertices to the rasterizer
- para_out  out  NSURF*6*PW  latched parameters to the rasterizer
- draw_start  out  1  one-cycle start pulse to the rasterizer
- draw_done  in  1  one-cycle done pulse from the rasterizer
- vsync  in  1  display vertical sync, synchronous to Clk
- buf_sel  out  1  displayed buffer; the rasterizer writes ~buf_sel
- busy  out  1  high in every state except IDLE
- frame_count  out  16  count of completed, swapped frames
- error  out  1  sticky watchdog flag (see Configuration)

## Operation
- FSM states: IDLE, LATCH, START, DRAW, SWAP_WAIT, SWAP.
- IDLE: frame_req=1 moves to LATCH.
- LATCH:
  - captures vertex_in and para_in into vertex_out and para_out
  - frame_ack=1 for this cycle
  - moves to START
- START: draw_start=1 for exactly one cycle; moves to DRAW.
- DRAW: waits for draw_done=1, then moves to SWAP_WAIT.
- SWAP_WAIT: waits for a vsync rising edge (vsync & ~vsync_q, with vsync_q a registered copy). The edge must be sampled while in SWAP_WAIT; earlier edges are ignored.
- SWAP: toggles buf_sel, increments frame_count, returns to IDLE.
- vertex_out and para_out change only in LATCH. They are stable for the whole draw.
- draw_done outside DRAW is ignored.
- frame_req asserted while busy is not lost. It is serviced on the first IDLE cycle after return.
- frame_count wraps from 0xFFFF to 0x0000.

## Timing
- All outputs are registered. Reset values:
  - frame_ack, draw_start, busy, error = 0
  - buf_sel = 0
  - frame_count = 0
  - vertex_out, para_out = 0
  - state = IDLE
- Latency: frame_req seen in IDLE at cycle n. frame_ack=1 at n+1 and draw_start=1 at n+2.
- draw_done at cycle m puts the FSM in SWAP_WAIT at m+1.
- A vsync edge detected at cycle k toggles buf_sel and updates frame_count at k+1. The FSM is back in IDLE at k+2.
- Back-to-back frames: with frame_req held, the next frame_ack comes one cycle after the FSM re-enters IDLE.
- Reset mid-operation: all registers return to reset values immediately. A later draw_done from the aborted draw is ignored.

## Configuration
- RENDER_WATCHDOG_EN defined:
  - a cycle counter runs in DRAW and clears on entry to DRAW
  - when it reaches TIMEOUT before draw_done, error is set (sticky until Reset) and the FSM returns to IDLE
  - no swap occurs and frame_count is unchanged
  - draw_done and timeout in the same cycle: draw_done wins
- RENDER_WATCHDOG_EN undefined: no counter; DRAW waits indefinitely; error is tied to 0.

## Test plan
- Reset, then frame_req=1 with vertex_in=pattern A; done 307200 cycles after start; vsync edge 100 cycles later -> frame_ack at n+1, draw_start at n+2, vertex_out=A throughout, buf_sel 0->1, frame_count=1.
- Change vertex_in to pattern B during DRAW -> vertex_out stays A until the next LATCH.
- vsync edge during DRAW, then none until 500 cycles into SWAP_WAIT -> swap only at the later edge.
- frame_req held continuously for 3 frames -> frame_count=3 and buf_sel=1, with one draw_start per frame.
- Reset asserted mid-DRAW, then a stray draw_done -> FSM stays IDLE, no swap, frame_count=0.
- With RENDER_WATCHDOG_EN and TIMEOUT=1000, withhold draw_done -> error=1 at cycle 1000 of DRAW, FSM in IDLE, buf_sel unchanged.
